// File: rtl/fir_stream_sequencer_if.sv
// Stream and filter-handshake bundle for fir_stream_sequencer.
// The master view belongs to the sequencer; the slave view belongs to the surrounding system.
interface fir_stream_sequencer_if #(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_OUT = 32
);
    logic [WIDTH_IN-1:0]  s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic                 fir_idle;
    logic                 fir_strobe_dataIn;
    logic [WIDTH_IN-1:0]  fir_dataIn;
    logic                 fir_strobe_dataOut;
    logic [WIDTH_OUT-1:0] fir_dataOut;
    logic [WIDTH_OUT-1:0] m_data;
    logic                 m_valid;
    logic                 m_ready;

    modport master (
        input  s_data, s_valid, fir_idle, fir_strobe_dataOut, fir_dataOut, m_ready,
        output s_ready, fir_strobe_dataIn, fir_dataIn, m_data, m_valid
    );

    modport slave (
        output s_data, s_valid, fir_idle, fir_strobe_dataOut, fir_dataOut, m_ready,
        input  s_ready, fir_strobe_dataIn, fir_dataIn, m_data, m_valid
    );
endinterface

// File: rtl/fir_stream_sequencer.sv
// Buffers upstream samples, loads them into the shared-multiplier filter at most once per
// three cycles, and captures the filter's unstallable result strobes into an output FIFO.
module fir_stream_sequencer #(
    parameter int WIDTH_IN   = 16,
    parameter int WIDTH_OUT  = 32,
    parameter int IN_DEPTH   = 8,
    parameter int OUT_DEPTH  = 16,
    parameter int OUT_MARGIN = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    fir_stream_sequencer_if.master    bus,
    output logic [CNT_WIDTH-1:0]      in_count,
    output logic [CNT_WIDTH-1:0]      out_count,
    output logic                      out_overflow
);

    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam int IN_LW  = IN_AW + 1;
    localparam int OUT_AW = $clog2(OUT_DEPTH);
    localparam int OUT_LW = OUT_AW + 1;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_ISSUE,
        ST_GAP
    } state_t;

    state_t state, state_next;

    // ---------------------------------------------------------------- input FIFO
    logic [WIDTH_IN-1:0] in_mem [IN_DEPTH];
    logic [IN_AW-1:0]    in_wr_ptr, in_rd_ptr;
    logic [IN_LW-1:0]    in_level;
    logic                in_full, in_empty, in_push, in_pop;

    assign in_full     = (in_level == IN_LW'(IN_DEPTH));
    assign in_empty    = (in_level == '0);
    assign bus.s_ready = !in_full && !rst_in;
    assign in_push     = bus.s_valid && bus.s_ready;
    assign in_pop      = (state == ST_ISSUE);

    // NOTE: storage arrays carry no reset; the pointers and level alone say which entries are live.
    always_ff @(posedge clk_in) begin
        if (in_push) in_mem[in_wr_ptr] <= bus.s_data;
    end

    // NOTE: sequential state is always updated with non-blocking assignments.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            in_wr_ptr <= '0;
            in_rd_ptr <= '0;
            in_level  <= '0;
        end else begin
            if (in_push) in_wr_ptr <= in_wr_ptr + IN_AW'(1);
            if (in_pop)  in_rd_ptr <= in_rd_ptr + IN_AW'(1);
            in_level <= in_level + IN_LW'(in_push) - IN_LW'(in_pop);
        end
    end

    // ---------------------------------------------------------------- output FIFO
    logic [WIDTH_OUT-1:0] out_mem [OUT_DEPTH];
    logic [OUT_AW-1:0]    out_wr_ptr, out_rd_ptr;
    logic [OUT_LW-1:0]    out_level, out_free;
    logic                 out_full, out_push, out_pop, out_drop;

    assign out_full    = (out_level == OUT_LW'(OUT_DEPTH));
    assign out_free    = OUT_LW'(OUT_DEPTH) - out_level;
    assign bus.m_valid = (out_level != '0);
    assign bus.m_data  = out_mem[out_rd_ptr];
    assign out_pop     = bus.m_valid && bus.m_ready;
    // A pop in the same cycle frees the slot the incoming result needs.
    assign out_push    = bus.fir_strobe_dataOut && !rst_in && (!out_full || out_pop);
    assign out_drop    = bus.fir_strobe_dataOut && !rst_in && out_full && !out_pop;

    always_ff @(posedge clk_in) begin
        if (out_push) out_mem[out_wr_ptr] <= bus.fir_dataOut;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            out_wr_ptr   <= '0;
            out_rd_ptr   <= '0;
            out_level    <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else begin
            if (out_push) begin
                out_wr_ptr <= out_wr_ptr + OUT_AW'(1);
                out_count  <= out_count + CNT_WIDTH'(1);
            end
            if (out_pop) out_rd_ptr <= out_rd_ptr + OUT_AW'(1);
            out_level <= out_level + OUT_LW'(out_push) - OUT_LW'(out_pop);
            if (out_drop) out_overflow <= 1'b1;
        end
    end

    // ---------------------------------------------------------------- load FSM
    logic                load_go;
    logic                strobe_q;
    logic [WIDTH_IN-1:0] data_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= ST_WAIT;
        else        state <= state_next;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        load_go    = 1'b0;
        case (state)
            ST_WAIT: begin
                if (bus.fir_idle && !in_empty && (out_free >= OUT_LW'(OUT_MARGIN))) begin
                    state_next = ST_ISSUE;
                    load_go    = 1'b1;
                end
            end
            ST_ISSUE: state_next = ST_GAP;
            // GAP lets fir_idle drop in response to the load before it is sampled again.
            ST_GAP:   state_next = ST_WAIT;
            default:  state_next = ST_WAIT;
        endcase
    end

    // The strobe register is high exactly while the FSM sits in ISSUE.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            strobe_q <= 1'b0;
            data_q   <= '0;
            in_count <= '0;
        end else begin
            strobe_q <= load_go;
            if (load_go) data_q   <= in_mem[in_rd_ptr];
            if (in_pop)  in_count <= in_count + CNT_WIDTH'(1);
        end
    end

    assign bus.fir_strobe_dataIn = strobe_q;
    assign bus.fir_dataIn        = data_q;

endmodule
